// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial link.
// Contents: link state encoding, line levels, and frame-length helper.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Frame length in clk cycles: start + data + optional parity + stop bits.
    function automatic int unsigned frame_cycles(
        input int unsigned width,
        input int unsigned clks_per_bit,
        input int unsigned stop_bits,
        input bit          parity_en
    );
        return (1 + width + 32'(parity_en) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Ports:
//   clk, rst_sync  clock and synchronous active-high reset
//   clear          hold the count at 0 (used while the link is idle)
//   tick_c         count is at terminal value this cycle
//   tick_next_c    count will be at terminal value next cycle
module serial_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_sync,
    input  logic clear,
    output logic tick_c,
    output logic tick_next_c
);

    localparam int unsigned CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned TC     = CLKS_PER_BIT - 1;
    localparam int unsigned PRE_TC = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0;

    logic [CW-1:0] count;

    // Wrapping cycle counter.
    always_ff @(posedge clk) begin
        if (rst_sync || clear || tick_c) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick_c = (count == CW'(TC));

    // Lookahead so the owner can register outputs tied to the terminal cycle.
    always_comb begin
        tick_next_c = 1'b0;
        if (CLKS_PER_BIT == 1) begin
            tick_next_c = 1'b1;
        end else if (!clear && !tick_c) begin
            tick_next_c = (count == CW'(PRE_TC));
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, data LSB first,
// optional even-parity bit, stop bit(s); each bit held CLKS_PER_BIT cycles.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (adds a parity bit).
// Ports:
//   clk, rst_sync      clock and synchronous active-high reset
//   in_data, in_valid  word offered for transmission
//   in_ready           accepting a word this cycle (IDLE only)
//   tx_out             serial line, idles high
//   busy               frame in progress
//   done               pulse on the last cycle of the final stop bit
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int unsigned FRAME_CYCLES = frame_cycles(WIDTH, CLKS_PER_BIT, STOP_BITS, PARITY_EN);

    // Reject unsupported configurations at elaboration.
    if (WIDTH < 1 || WIDTH > 32 || CLKS_PER_BIT < 1 || STOP_BITS < 1 || STOP_BITS > 2
        || FRAME_CYCLES < 3) begin : g_bad_cfg
        $error("serial_frame_tx: unsupported parameter set");
    end

    link_state_e      state_q, state_n;
    logic [BW-1:0]    bit_q, bit_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic             tx_n, done_n;
    logic             tick_c, tick_next_c;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             parity_q, parity_n;
`endif

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk         (clk),
        .rst_sync    (rst_sync),
        .clear       (state_q == IDLE),
        .tick_c      (tick_c),
        .tick_next_c (tick_next_c)
    );

    // Next-state and next-output logic; outputs are registered from next values.
    always_comb begin
        state_n  = state_q;
        bit_n    = bit_q;
        shift_n  = shift_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_n = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_n  = START;
                    shift_n  = in_data;
                    bit_n    = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_n = ^in_data;
`endif
                end
            end
            START: begin
                if (tick_c) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (tick_c) begin
                    shift_n = shift_q >> 1;
                    if (bit_q == BW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_q + BW'(1);
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick_c) begin
                    state_n = STOP;
                    bit_n   = '0;
                end
            end
`endif
            STOP: begin
                if (tick_c) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                bit_n   = '0;
            end
        endcase

        // Line level for the cycle after this edge.
        unique case (state_n)
            START:   tx_n = START_LEVEL;
            DATA:    tx_n = shift_n[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = IDLE_LEVEL;
        endcase

        done_n = (state_n == STOP) && (bit_n == BW'(STOP_BITS - 1)) && tick_next_c;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_out   <= IDLE_LEVEL;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            bit_q    <= bit_n;
            shift_q  <= shift_n;
            tx_out   <= tx_n;
            in_ready <= (state_n == IDLE);
            busy     <= (state_n != IDLE);
            done     <= done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx (default WIDTH=8, CLKS_PER_BIT=4,
// STOP_BITS=1); follows SERIAL_FRAME_TX_PARITY_EN when defined.
module tb_serial_frame_tx;
    import serial_link_pkg::*;

    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam bit PAR     = 1'b1;
    localparam int EXP_LEN = 44;
`else
    localparam bit PAR     = 1'b0;
    localparam int EXP_LEN = 40;
`endif
    localparam int FL = int'(frame_cycles(W, CPB, SB, PAR));

    logic         clk = 1'b0;
    logic         rst_sync;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         tx_out;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_frame_tx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_out   (tx_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level c cycles into a frame carrying w.
    function automatic logic exp_level(input logic [W-1:0] w, input int c);
        int idx;
        idx = c / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= W) return w[idx-1];
        if (PAR && idx == W + 1) return ^w;
        return 1'b1;
    endfunction

    // Launch w from an idle negedge and check every frame cycle. From frame
    // cycle hold_from on, in_valid is held with nxt (ignored until idle).
    task automatic send_frame(input logic [W-1:0] w, input int hold_from, input logic [W-1:0] nxt,
                              output int busy_cnt, output int start_at, output int done_at);
        logic exp_done;
        busy_cnt = 0;
        start_at = -1;
        done_at  = -1;
        checks++;
        if (in_ready !== 1'b1 || tx_out !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_before_frame: ready=%b tx=%b busy=%b, expected 1 1 0", in_ready, tx_out, busy);
        end
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        start_at = cyc;
        for (int c = 0; c < FL; c++) begin
            if (hold_from >= 0 && c >= hold_from) begin
                in_valid = 1'b1;
                in_data  = nxt;
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end
            exp_done = (c == FL - 1);
            checks++;
            if (tx_out !== exp_level(w, c)) begin
                failures++;
                $display("FAIL tx_bit word=%h cycle=%0d: got %b expected %b", w, c, tx_out, exp_level(w, c));
            end
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_ready cycle=%0d: busy=%b ready=%b expected 1 0", c, busy, in_ready);
            end
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL done cycle=%0d: got %b expected %b", c, done, exp_done);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_at = cyc;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_sync = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx_out); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        rst_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int b, s, d;
        send_frame(8'hA5, -1, '0, b, s, d);
        checks++;
        if (b != EXP_LEN) begin
            failures++;
            $display("FAIL frame_length: busy cycles %0d expected %0d", b, EXP_LEN);
        end
    endtask

    task automatic test_back_to_back();
        int b, s1, d1, s2, d2;
        send_frame(8'h3C, 0, 8'hC3, b, s1, d1);
        send_frame(8'hC3, -1, '0, b, s2, d2);
        checks++;
        if (s2 - d1 != 2) begin
            failures++;
            $display("FAIL b2b_gap: second start %0d cycles after done, expected 2", s2 - d1);
        end
    endtask

    task automatic test_ignored_input();
        int b, s, d;
        send_frame(8'h00, 3, 8'hFF, b, s, d);
        send_frame(8'hFF, -1, '0, b, s, d);
    endtask

    task automatic test_mid_frame_reset();
        in_data  = W'($urandom);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst_sync = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort: tx=%b busy=%b ready=%b done=%b expected 1 0 1 0", tx_out, busy, in_ready, done);
        end
        rst_sync = 1'b0;
        for (int i = 0; i < FL + 8; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL after_abort cycle=%0d: done=%b tx=%b busy=%b expected 0 1 0", i, done, tx_out, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w, nxt;
        bit chain;
        int hf, b, s, d;
        w = W'($urandom);
        for (int i = 0; i < 20; i++) begin
            chain = ($urandom_range(0, 1) == 1) && (i < 19);
            nxt   = W'($urandom);
            hf    = chain ? int'($urandom_range(0, FL - 1)) : -1;
            send_frame(w, hf, nxt, b, s, d);
            if (chain) begin
                w = nxt;
            end else begin
                w = W'($urandom);
                repeat ($urandom_range(0, 3)) begin
                    checks++;
                    if (tx_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL idle_gap: tx=%b busy=%b ready=%b expected 1 0 1", tx_out, busy, in_ready);
                    end
                    in_data = W'($urandom);
                    @(negedge clk);
                end
            end
        end
    endtask

`ifdef SERIAL_FRAME_TX_PARITY_EN
    task automatic test_parity();
        int b, s, d;
        send_frame(8'h07, -1, '0, b, s, d);
        checks++;
        if (b != 44) begin
            failures++;
            $display("FAIL parity_length: busy cycles %0d expected 44", b);
        end
    endtask
`endif

    initial begin
        rst_sync = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_input();
        test_mid_frame_reset();
`ifdef SERIAL_FRAME_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial framed transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single serial line.
- Frame: start bit, data LSB first, stop bit; each bit held for CLKS_PER_BIT cycles.
- Sits at the transmit end of the team's bit-serial link. It produces the serial stream that the flip-flop-based capture logic on the far end samples.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_sync  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  transmitter can accept a word this cycle.
- tx_out  output  1  serial line; idle level 1.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst_sync.
- Reset values: tx_out=1, in_ready=1, busy=0, done=0. State IDLE, shift register 0, counters 0.
- Handshake:
  - Transfer occurs on a rising edge where in_valid && in_ready.
  - in_data is latched into the shift register at that edge.
  - in_ready is 1 only in IDLE; it is registered and drops on the cycle after the transfer.
  - in_valid while in_ready=0 is ignored; there is no buffering.
- States:
  - IDLE -> START on transfer.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after WIDTH bits.
  - STOP -> IDLE after STOP_BITS*CLKS_PER_BIT cycles.
- Latency: tx_out goes 0 (start bit) on the first cycle after the transfer edge.
- Bit timing:
  - Cycle counter runs 0..CLKS_PER_BIT-1; at terminal count it advances the bit.
  - Bit index counter width is $clog2(WIDTH+1).
  - Data is shifted right; tx_out = shift_reg[0] during DATA.
- Total frame length: (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles with busy=1. busy=0 in IDLE.
- done:
  - Asserted on the final stop-bit cycle.
  - The state returns to IDLE on the next cycle; in_ready=1 then.
  - Back-to-back frames: a word offered with in_valid held high is accepted on the first IDLE cycle. Minimum gap is one idle cycle at tx_out=1.
- CLKS_PER_BIT=1: every state transition happens on every cycle; no extra idle cycles are inserted beyond the one-cycle IDLE.
- Reset mid-frame:
  - rst_sync has priority over all other inputs.
  - The frame is aborted: tx_out=1 and the IDLE/reset values apply on the next edge.
  - No done pulse is generated.
- A change on in_data after acceptance has no effect on the frame in flight.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP for one bit time.
  - tx_out carries the even-parity bit, the XOR of the accepted word, computed at acceptance.
  - Frame length becomes (2+WIDTH+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic. Frame as above.

Decomposition:
- Package serial_link_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constant IDLE_LEVEL=1'b1 and START_LEVEL=1'b0.
  - A function returning frame length in cycles, used by both the RTL and the bench.
- One natural sub-module: serial_bit_timer. It is the CLKS_PER_BIT cycle counter with a load/clear input and a terminal-count tick output, reusable by the matching receiver.

Test Plan:
- Reset check: hold rst_sync=1 for 3 cycles -> tx_out=1, in_ready=1, busy=0, done=0.
- Single frame, WIDTH=8, CLKS_PER_BIT=4, in_data=8'hA5 -> sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy high for 40 cycles; done pulses once at cycle 40.
- Back-to-back with in_valid held high: 8'h3C then 8'hC3 -> second start bit begins exactly 2 cycles after the first done. Both frames decode correctly.
- Ignored input: assert in_valid with 8'hFF during a 8'h00 frame -> line shows only 8'h00; 8'hFF accepted only after in_ready returns.
- Mid-frame reset: rst_sync=1 at cycle 15 of a frame -> tx_out=1, busy=0, in_ready=1 next edge; no done pulse.
- With SERIAL_FRAME_TX_PARITY_EN, in_data=8'h07 -> parity bit 1 after bit 7. Frame length 44 cycles at CLKS_PER_BIT=4.
